// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents: controller state encoding (2 bits), default drain length and the
// syscall code that terminates the program.
package hazard_pkg;

  localparam logic [1:0] HZ_RUN   = 2'd0;
  localparam logic [1:0] HZ_DRAIN = 2'd1;
  localparam logic [1:0] HZ_ISSUE = 2'd2;
  localparam logic [1:0] HZ_HALT  = 2'd3;

  typedef enum logic [1:0] {
    StRun   = HZ_RUN,
    StDrain = HZ_DRAIN,
    StIssue = HZ_ISSUE,
    StHalt  = HZ_HALT
  } hz_state_e;

  // Bubbles inserted ahead of a syscall; legal range 1..7.
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned DrainCntW        = 3;

  // $v0 value of the exit syscall.
  localparam logic [31:0] SYSCALL_EXIT_CODE = 32'd10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline.
// master: controller view (decode / pipeline-register fields in, write/clear controls out).
// slave : pipeline view (the reverse).
// With HAZARD_PERF_CNT_EN defined, two 32-bit performance counters are added.
interface hazard_ctrl_if;

  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        idUsesRt;
  logic        idSyscall;
  logic        idSyscallExit;
  logic        exeMemRead;
  logic [4:0]  exeRt;
  logic        memBranchTaken;

  logic        pcWrite;
  logic        ifIdWrite;
  logic        ifIdReset;
  logic        idExeWrite;
  logic        idExeReset;
  logic        exeMemReset;
  logic        syscallFire;
  logic        halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCount;
  logic [31:0] flushCount;
`endif

  modport master (
    input  idRs, idRt, idUsesRt, idSyscall, idSyscallExit, exeMemRead, exeRt, memBranchTaken,
    output pcWrite, ifIdWrite, ifIdReset, idExeWrite, idExeReset, exeMemReset, syscallFire,
    output halted
`ifdef HAZARD_PERF_CNT_EN
    , output stallCount, flushCount
`endif
  );

  modport slave (
    output idRs, idRt, idUsesRt, idSyscall, idSyscallExit, exeMemRead, exeRt, memBranchTaken,
    input  pcWrite, ifIdWrite, ifIdReset, idExeWrite, idExeReset, exeMemReset, syscallFire,
    input  halted
`ifdef HAZARD_PERF_CNT_EN
    , input stallCount, flushCount
`endif
  );

endinterface

// File: rtl/hazard_load_use_cmp.sv
// Load-use register-match comparator.
// Inputs : ID source fields (rs, rt, rt-used flag), ID/EXE memRead and rt.
// Output : hazard_o, set when the load in EXE writes a register the ID instruction reads.
module hazard_load_use_cmp (
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       exe_mem_read_i,
  input  logic [4:0] exe_rt_i,
  output logic       hazard_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (exe_rt_i == id_rs_i);
    rt_match = id_uses_rt_i && (exe_rt_i == id_rt_i);
    // $zero is never really written, so a load targeting it cannot create a dependency.
    hazard_o = exe_mem_read_i && (exe_rt_i != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes (branches resolve in
// MEM), syscall drain/issue and program halt.
// Ports: clk, reset (synchronous, active-high), hz (hazard_ctrl_if.master).
// Parameter DRAIN_CYCLES (1..7): bubbles inserted before a syscall leaves ID.
// Optional macro HAZARD_PERF_CNT_EN adds stallCount / flushCount counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.master hz
);

  hz_state_e            state_q, state_d;
  logic [DrainCntW-1:0] cnt_q, cnt_d;
  logic                 load_use;
  logic                 flush;

  logic pc_write, if_id_write, if_id_reset, id_exe_write, id_exe_reset, exe_mem_reset;
  logic syscall_fire, halted;

  hazard_load_use_cmp u_load_use_cmp (
    .id_rs_i        (hz.idRs),
    .id_rt_i        (hz.idRt),
    .id_uses_rt_i   (hz.idUsesRt),
    .exe_mem_read_i (hz.exeMemRead),
    .exe_rt_i       (hz.exeRt),
    .hazard_o       (load_use)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush         = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_reset   = 1'b0;
    id_exe_write  = 1'b1;
    id_exe_reset  = 1'b0;
    exe_mem_reset = 1'b0;
    syscall_fire  = 1'b0;
    halted        = 1'b0;

    if (reset) begin
      // Outputs stay at RUN defaults; state/counter clear in the register.
    end else if (state_q == StHalt) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_exe_write = 1'b0;
      halted       = 1'b1;
    end else if (hz.memBranchTaken) begin
      // Everything younger than the branch is wrong-path, including a draining syscall.
      flush         = 1'b1;
      if_id_reset   = 1'b1;
      id_exe_reset  = 1'b1;
      exe_mem_reset = 1'b1;
      state_d       = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.idSyscall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_exe_reset = 1'b1;
            cnt_d        = DrainCntW'(DRAIN_CYCLES);
            state_d      = (cnt_d == DrainCntW'(1)) ? StIssue : StDrain;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_exe_reset = 1'b1;
          end
        end
        StDrain: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_exe_reset = 1'b1;
          cnt_d        = cnt_q - DrainCntW'(1);
          state_d      = (cnt_d == DrainCntW'(1)) ? StIssue : StDrain;
        end
        StIssue: begin
          syscall_fire = 1'b1;
          state_d      = hz.idSyscallExit ? StHalt : StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pcWrite     = pc_write;
  assign hz.ifIdWrite   = if_id_write;
  assign hz.ifIdReset   = if_id_reset;
  assign hz.idExeWrite  = id_exe_write;
  assign hz.idExeReset  = id_exe_reset;
  assign hz.exeMemReset = exe_mem_reset;
  assign hz.syscallFire = syscall_fire;
  assign hz.halted      = halted;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(!pc_write && !halted);
    flush_cnt_d = flush_cnt_q + 32'(flush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stallCount = stall_cnt_q;
  assign hz.flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed sequences with literal expectations, then randomized
// traffic checked every cycle against a cycle-count based reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned D = DRAIN_CYCLES_DEF;

  // {pcWrite, ifIdWrite, ifIdReset, idExeWrite, idExeReset, exeMemReset, syscallFire, halted}
  localparam logic [7:0] V_DEF   = 8'b1101_0000;
  localparam logic [7:0] V_STALL = 8'b0001_1000;
  localparam logic [7:0] V_FLUSH = 8'b1111_1100;
  localparam logic [7:0] V_FIRE  = 8'b1101_0010;
  localparam logic [7:0] V_HALT  = 8'b0000_0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(.DRAIN_CYCLES(D)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a syscall accepted at cycle t fires at absolute cycle t + D.
  int unsigned cyc       = 0;
  bit          m_halted  = 1'b0;
  bit          m_pend    = 1'b0;
  int unsigned m_fire_at = 0;
  logic [31:0] m_stall   = '0;
  logic [31:0] m_flush   = '0;

  bit          lit_valid = 1'b0;
  logic [7:0]  lit_exp   = '0;
  string       lit_name  = "";
  bit          perf_lit  = 1'b0;

  function automatic logic [7:0] dut_vec();
    return {hz_if.pcWrite, hz_if.ifIdWrite, hz_if.ifIdReset, hz_if.idExeWrite,
            hz_if.idExeReset, hz_if.exeMemReset, hz_if.syscallFire, hz_if.halted};
  endfunction

  function automatic bit model_hazard();
    return hz_if.exeMemRead && (hz_if.exeRt != 5'd0) &&
           ((hz_if.exeRt == hz_if.idRs) || (hz_if.idUsesRt && (hz_if.exeRt == hz_if.idRt)));
  endfunction

  function automatic logic [7:0] model_out();
    if (reset) return V_DEF;
    if (m_halted) return V_HALT;
    if (hz_if.memBranchTaken) return V_FLUSH;
    if (m_pend) return (cyc == m_fire_at) ? V_FIRE : V_STALL;
    if (hz_if.idSyscall || model_hazard()) return V_STALL;
    return V_DEF;
  endfunction

  // Model state update at the active edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (reset) begin
        m_halted <= 1'b0;
        m_pend   <= 1'b0;
        m_stall  <= '0;
        m_flush  <= '0;
      end else if (!m_halted) begin
        if ((model_out() & 8'h80) == 8'h00) m_stall <= m_stall + 32'd1;
        if (hz_if.memBranchTaken) begin
          m_flush <= m_flush + 32'd1;
          m_pend  <= 1'b0;
        end else if (m_pend && (cyc == m_fire_at)) begin
          m_pend <= 1'b0;
          if (hz_if.idSyscallExit) m_halted <= 1'b1;
        end else if (!m_pend && hz_if.idSyscall) begin
          m_pend    <= 1'b1;
          m_fire_at <= cyc + D;
        end
      end
    end
  end

  // Compare process, sampling on the falling edge.
  initial begin
    logic [7:0] act;
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      act   = dut_vec();
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL model cyc=%0d: got %b, expected %b", cyc, act, exp_v);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (hz_if.stallCount !== m_stall) begin
        errors++;
        $display("FAIL stallCount cyc=%0d: got %0d, expected %0d", cyc, hz_if.stallCount, m_stall);
      end
      checks++;
      if (hz_if.flushCount !== m_flush) begin
        errors++;
        $display("FAIL flushCount cyc=%0d: got %0d, expected %0d", cyc, hz_if.flushCount, m_flush);
      end
      if (perf_lit) begin
        checks++;
        if (hz_if.stallCount !== 32'd3 || hz_if.flushCount !== 32'd1) begin
          errors++;
          $display("FAIL perf_literal: got stall=%0d flush=%0d, expected stall=3 flush=1",
                   hz_if.stallCount, hz_if.flushCount);
        end
      end
`endif
      if (lit_valid) begin
        checks++;
        if (act !== lit_exp) begin
          errors++;
          $display("FAIL %s: got %b, expected %b", lit_name, act, lit_exp);
        end
      end
    end
  end

  task automatic step(input bit rst, input bit mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input bit urt, input bit sys, input bit ex,
                      input bit br, input bit lv, input logic [7:0] le, input string nm);
    reset                = rst;
    hz_if.exeMemRead     = mr;
    hz_if.exeRt          = ert;
    hz_if.idRs           = rs;
    hz_if.idRt           = rt;
    hz_if.idUsesRt       = urt;
    hz_if.idSyscall      = sys;
    hz_if.idSyscallExit  = ex;
    hz_if.memBranchTaken = br;
    lit_valid            = lv;
    lit_exp              = le;
    lit_name             = nm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    step(1, 1, 5'd8, 5'd8, 0, 0, 0, 0, 0, 1, V_DEF, "reset_defaults");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_DEF, "reset_defaults2");
    // Load-use: one stall, then bubble removes the hazard
    step(0, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0, 1, V_STALL, "load_use_rs");
    step(0, 0, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0, 1, V_DEF, "load_use_after");
    // Zero register and unused rt
    step(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1, V_DEF, "zero_reg");
    step(0, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0, 1, V_DEF, "rt_unused");
    step(0, 1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0, 1, V_STALL, "rt_used");
    // Flush beats load-use
    step(0, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 1, 1, V_FLUSH, "flush_over_load_use");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_DEF, "idle");
    // Syscall: D bubbles then fire
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_STALL, "sys_drain0");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_STALL, "sys_drain1");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_STALL, "sys_drain2");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_FIRE, "sys_fire");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_DEF, "sys_back_to_run");
    // Abort by branch during drain
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_STALL, "abort_drain0");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_STALL, "abort_drain1");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, V_FLUSH, "abort_flush");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_DEF, "abort_no_fire");
    // Exit syscall then halt
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, V_STALL, "exit_drain");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, V_FIRE, "exit_fire");
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 5'd8, 5'd8, 0, 0, i % 3 == 0, 0, i % 2 == 0, 1, V_HALT, "halt_hold");
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, V_DEF, "reset_in_halt");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_DEF, "run_after_halt");
    // Flush plus one syscall after reset: 3 stalls, 1 flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, V_FLUSH, "perf_flush");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_STALL, "perf_drain");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, V_FIRE, "perf_fire");
    perf_lit = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_DEF, "perf_idle");
    perf_lit = 1'b0;

    // Randomized traffic, model-checked only
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 4, 1'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           0, V_DEF, "");
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller driving the `write`/`reset` control side of the IF/ID, ID/EXE and EXE/MEM pipeline registers. The pipeline registers only store; this block decides when each one holds, loads, or is cleared. It handles:
- load-use stalls, by inserting an ID/EXE bubble;
- taken-branch flushes, with branches resolved in MEM;
- syscall drain/issue and program halt.

It sits beside the ID stage. Its inputs are the ID-stage decode fields and the ID/EXE and EXE/MEM register outputs.

## Interface
- `DRAIN_CYCLES`, 3: cycles of bubbles inserted before a syscall leaves ID; legal 1..7.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `idRs`, `idRt`  in  5 each  source fields of the instruction in ID.
- `idUsesRt`  in  1  the ID instruction reads rt as a source.
- `idSyscall`  in  1  the ID instruction is a syscall.
- `idSyscallExit`  in  1  the syscall in ID is the exit call ($v0 == 10).
- `exeMemRead`  in  1  memRead output of ID/EXE.
- `exeRt`  in  5  instrRt output of ID/EXE.
- `memBranchTaken`  in  1  a taken branch is in MEM.
- `pcWrite`  out  1  PC load enable.
- `ifIdWrite`  out  1  IF/ID write.
- `ifIdReset`  out  1  IF/ID clear.
- `idExeWrite`  out  1  ID/EXE write.
- `idExeReset`  out  1  ID/EXE clear (bubble).
- `exeMemReset`  out  1  EXE/MEM clear.
- `syscallFire`  out  1  one-cycle pulse as the syscall enters ID/EXE.
- `halted`  out  1  the pipeline is frozen.

## Operation
- States: RUN, DRAIN, ISSUE, HALT.
- Defaults in RUN: all three write outputs = 1; all three reset outputs = 0; `syscallFire` = 0; `halted` = 0.
- Branch flush: if `memBranchTaken` is set in RUN, DRAIN or ISSUE:
  - `ifIdReset` = `idExeReset` = `exeMemReset` = 1 and `pcWrite` = 1, for that cycle;
  - the next state is RUN, and any pending drain is abandoned (the syscall was on the wrong path);
  - this is the highest priority.
- Load-use, RUN only: hazard = `exeMemRead` AND `exeRt` != 0 AND (`exeRt` == `idRs` OR (`idUsesRt` AND `exeRt` == `idRt`)). When the hazard is set:
  - `pcWrite` = 0, `ifIdWrite` = 0, `idExeReset` = 1, for that cycle;
  - the state stays RUN.
- Syscall entry: if `idSyscall` is set in RUN with no flush, the next state is DRAIN.
  - The counter loads `DRAIN_CYCLES`.
  - The current cycle behaves as a drain cycle.
  - Drain entry subsumes a simultaneous load-use hazard.
- DRAIN:
  - Every cycle: `pcWrite` = 0, `ifIdWrite` = 0, `idExeReset` = 1.
  - The counter decrements each cycle.
  - When the counter reaches 1, the next state is ISSUE.
- ISSUE:
  - RUN defaults apply, plus `syscallFire` = 1.
  - If `idSyscallExit` is set, the next state is HALT; otherwise RUN.
- HALT:
  - All write outputs = 0, all reset outputs = 0, `halted` = 1.
  - `memBranchTaken` is ignored.
  - The only exit is `reset`.
- `exeRt` == 0 never causes a stall.

## Timing
- Hazard and flush outputs are combinational from the inputs and the current state, so they take effect at the same clock edge.
- State and counter are registered.
- While `reset` is high:
  - outputs are forced to RUN defaults;
  - the state becomes RUN and the counter becomes 0 at the edge;
  - performance counters clear.
- Reset mid-DRAIN: returns to RUN next cycle; no `syscallFire`.
- Syscall latency: `idSyscall` seen at cycle t gives `syscallFire` at cycle t + `DRAIN_CYCLES`.
- Load-use stall length: exactly 1 cycle. In the following cycle `exeMemRead` is 0 because of the bubble.

## Configuration
- Macro: `HAZARD_PERF_CNT_EN`.
- Defined: adds two 32-bit outputs.
  - `stallCount` increments on every cycle with `pcWrite` = 0 and `halted` = 0.
  - `flushCount` increments on every branch flush.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - state encoding constants `HZ_RUN`, `HZ_DRAIN`, `HZ_ISSUE`, `HZ_HALT` (2 bits);
  - default value of `DRAIN_CYCLES`;
  - `SYSCALL_EXIT_CODE` = 10.
- One sub-module: `hazard_load_use_cmp`, the combinational register-match comparator that produces the hazard bit.
- The FSM, drain counter and performance counters live in `hazard_ctrl`.

## Test plan
- Load-use: `exeMemRead`=1, `exeRt`=8, `idRs`=8 → one cycle of `pcWrite`=0, `ifIdWrite`=0, `idExeReset`=1. The next cycle, with `exeMemRead`=0, gives all RUN defaults.
- Zero register: `exeMemRead`=1, `exeRt`=0, `idRs`=0 → no stall. Also `idRt`=9 with `idUsesRt`=0 and `exeRt`=9 → no stall.
- Branch flush: `memBranchTaken`=1 during a load-use hazard → all three resets = 1, `pcWrite`=1, `idExeWrite`=1; the flush wins.
- Syscall: `idSyscall`=1 with `DRAIN_CYCLES`=3 → 3 bubble cycles, then `syscallFire` at t+3, then RUN. With `idSyscallExit`=1 → HALT and `halted`=1 held for 10 or more cycles regardless of `memBranchTaken`.
- Abort and reset: a branch flush in the 2nd drain cycle gives RUN with no `syscallFire`. `reset` in HALT gives RUN next cycle. With `HAZARD_PERF_CNT_EN`, `stallCount`=3 and `flushCount`=1 after the branch-flush and syscall sequences.
